// File: rtl/cadder_pkg.sv
// Shared types and constants for the cadder_pipe block: operation modes and
// the upper bound on pipeline depth.
package cadder_pkg;

  localparam int MAX_LATENCY = 4;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/cadder_core.sv
// Combinational WIDTH+1-bit ripple adder, S = X + Y + cin (mod 2^(WIDTH+1)).
// With CARRY_ERROR nonzero the carry out of bit ERR_BIT is forced to 0.
module cadder_core #(
  parameter int WIDTH       = 4,
  parameter int CARRY_ERROR = 0,
  parameter int ERR_BIT     = 0
) (
  input  logic [WIDTH:0] X,
  input  logic [WIDTH:0] Y,
  input  logic           cin,
  output logic [WIDTH:0] S
);

  // w_c[i] is the carry into bit i; the carry out of the MSB is discarded.
  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    if (CARRY_ERROR != 0 && i == ERR_BIT) begin : g_drop
      assign w_c[i+1] = 1'b0;
    end else begin : g_pass
      assign w_c[i+1] = (X[i] & Y[i]) | (w_c[i] & (X[i] ^ Y[i]));
    end
  end

  assign S = X ^ Y ^ w_c;

endmodule

// File: rtl/cadder_pipe.sv
// Pipelined add/sub/accumulate unit with valid/ready handshake and full-stall
// backpressure. Optional sticky accumulator overflow flag: CADDER_PIPE_OVF_EN.
module cadder_pipe
  import cadder_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LATENCY     = 2,
  parameter int CARRY_ERROR = 0,
  parameter int ERR_BIT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Z
`ifdef CADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Out-of-range depths saturate to the legal 1..MAX_LATENCY window.
  localparam int STAGES = (LATENCY < 1) ? 1 :
                          (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

  mode_e          w_mode;
  logic           w_stall;
  logic           w_accept;
  logic [WIDTH:0] w_x;
  logic [WIDTH:0] w_y;
  logic           w_cin;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_result;

  logic [WIDTH:0]    r_acc;
  logic [WIDTH:0]    r_data [STAGES];
  logic [STAGES-1:0] r_vld;

  assign w_mode    = mode_e'(mode);
  assign w_stall   = out_valid && !out_ready;
  assign in_ready  = !w_stall;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_vld[STAGES-1];
  assign Z         = r_data[STAGES-1];

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_x      = {1'b0, A};
    w_y      = {1'b0, B};
    w_cin    = 1'b0;
    w_result = w_sum;
    case (w_mode)
      MODE_SUB: begin
        w_y   = ~{1'b0, B};
        w_cin = 1'b1;
      end
      MODE_ACC: begin
        w_x = r_acc;
        w_y = {1'b0, A};
      end
      MODE_LOAD: w_result = {1'b0, A};
      default: ;
    endcase
  end

  cadder_core #(
    .WIDTH      (WIDTH),
    .CARRY_ERROR(CARRY_ERROR),
    .ERR_BIT    (ERR_BIT)
  ) u_core (
    .X  (w_x),
    .Y  (w_y),
    .cin(w_cin),
    .S  (w_sum)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, which is what makes the shift work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_acc <= '0;
      // NOTE: the data stages are reset too, because Z must read 0 during and
      // right after reset rather than whatever was in flight.
      for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
    end else begin
      if (!w_stall) begin
        r_vld[0]  <= in_valid;
        r_data[0] <= w_result;
        for (int i = 1; i < STAGES; i++) begin
          r_vld[i]  <= r_vld[i-1];
          r_data[i] <= r_data[i-1];
        end
      end
      if (w_accept && (w_mode == MODE_ACC || w_mode == MODE_LOAD)) r_acc <= w_result;
    end
  end

`ifdef CADDER_PIPE_OVF_EN
  // Exact sum with one spare bit, independent of any injected carry fault.
  logic [WIDTH+1:0] w_true_sum;
  logic             r_ovf;

  assign w_true_sum = {1'b0, r_acc} + {2'b00, A};
  assign ovf        = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_mode == MODE_ACC && w_true_sum[WIDTH+1]) r_ovf <= 1'b1;
      else if (w_mode == MODE_LOAD) r_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cadder_pipe.sv
// Self-checking bench for cadder_pipe: vector table through a scoreboard,
// plus directed stall, reset, carry-fault and (optional) overflow sequences.
module tb_cadder_pipe;
  import cadder_pkg::*;

  localparam int W   = 4;
  localparam int LAT = 2;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    mode_e        m;
    logic [W:0]   z;
  } vec_t;

  typedef struct {
    logic [W:0] z;
    int         cyc;
    bit         chk_lat;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  mode_e        mode;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   Z;

  logic         e_valid;
  logic [W-1:0] e_a;
  logic [W-1:0] e_b;
  mode_e        e_mode;
  logic         e_oready;
  logic         e3_rdy, e0_rdy, e3_ov, e0_ov;
  logic [W:0]   e3_z, e0_z;

`ifdef CADDER_PIPE_OVF_EN
  logic ovf, e3_ovf, e0_ovf;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  sb_t  sb_q[$];
  vec_t vecs[14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cadder_pipe #(.WIDTH(W), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z)
`ifdef CADDER_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  cadder_pipe #(.WIDTH(W), .LATENCY(LAT), .CARRY_ERROR(1), .ERR_BIT(3)) u_err3 (
    .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(e3_rdy),
    .A(e_a), .B(e_b), .mode(e_mode), .out_valid(e3_ov), .out_ready(e_oready),
    .Z(e3_z)
`ifdef CADDER_PIPE_OVF_EN
    , .ovf(e3_ovf)
`endif
  );

  cadder_pipe #(.WIDTH(W), .LATENCY(LAT), .CARRY_ERROR(1), .ERR_BIT(0)) u_err0 (
    .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(e0_rdy),
    .A(e_a), .B(e_b), .mode(e_mode), .out_valid(e0_ov), .out_ready(e_oready),
    .Z(e0_z)
`ifdef CADDER_PIPE_OVF_EN
    , .ovf(e0_ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input mode_e m, input logic [W:0] acc);
    logic [W:0] r;
    case (m)
      MODE_ADD: r = {1'b0, a} + {1'b0, b};
      MODE_SUB: r = {1'b0, a} - {1'b0, b};
      MODE_ACC: r = acc + {1'b0, a};
      default:  r = {1'b0, a};
    endcase
    return r;
  endfunction

  // Scoreboard: compare every delivered result against the queue head.
  always begin
    sb_t e;
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("z", {27'd0, Z}, {27'd0, e.z});
        if (e.chk_lat) check("latency", cyc - e.cyc, LAT);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input mode_e m,
                      input logic [W:0] exp, input bit chk_lat);
    sb_t e;
    int  n;
    @(negedge clk);
    A = a; B = b; mode = m; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    e.z = exp; e.cyc = cyc; e.chk_lat = chk_lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
  endtask

  task automatic err_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] z3, input logic [W:0] z0);
    @(negedge clk);
    e_a = a; e_b = b; e_mode = MODE_ADD; e_valid = 1'b1;
    @(posedge clk);
    #1 e_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("err3_valid", {31'd0, e3_ov}, 32'd1);
    check("err3_z", {27'd0, e3_z}, {27'd0, z3});
    check("err0_z", {27'd0, e0_z}, {27'd0, z0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] m_acc;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; mode = MODE_ADD; out_ready = 1'b1;
    e_valid = 1'b0; e_a = '0; e_b = '0; e_mode = MODE_ADD; e_oready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_z", {27'd0, Z}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Dropped carries: bit 3 turns 9+8 into 1, bit 0 turns 1+1 into 0.
    err_vec(4'd9, 4'd8, 5'd1, 5'd17);
    err_vec(4'd1, 4'd1, 5'd2, 5'd0);

    vecs[0]  = '{4'd9,  4'd8,  MODE_ADD,  5'd0};
    vecs[1]  = '{4'd0,  4'd0,  MODE_ADD,  5'd0};
    vecs[2]  = '{4'd15, 4'd15, MODE_ADD,  5'd0};
    vecs[3]  = '{4'd3,  4'd5,  MODE_SUB,  5'd0};
    vecs[4]  = '{4'd5,  4'd3,  MODE_SUB,  5'd0};
    vecs[5]  = '{4'd0,  4'd15, MODE_SUB,  5'd0};
    vecs[6]  = '{4'd7,  4'd7,  MODE_SUB,  5'd0};
    vecs[7]  = '{4'd15, 4'd3,  MODE_LOAD, 5'd0};
    vecs[8]  = '{4'd15, 4'd9,  MODE_ACC,  5'd0};
    vecs[9]  = '{4'd15, 4'd0,  MODE_ACC,  5'd0};
    vecs[10] = '{4'd1,  4'd6,  MODE_ACC,  5'd0};
    vecs[11] = '{4'd0,  4'd0,  MODE_LOAD, 5'd0};
    vecs[12] = '{4'd5,  4'd0,  MODE_ACC,  5'd0};
    vecs[13] = '{4'd15, 4'd0,  MODE_ADD,  5'd0};
    m_acc = '0;
    for (int i = 0; i < 14; i++) begin
      vecs[i].z = ref_op(vecs[i].a, vecs[i].b, vecs[i].m, m_acc);
      if (vecs[i].m == MODE_ACC || vecs[i].m == MODE_LOAD) m_acc = vecs[i].z;
    end
    for (int i = 0; i < 14; i++) send(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].z, 1'b1);
    drain();

    // Back-to-back load/accumulate with wrap; sticky overflow when enabled.
    send(4'd15, 4'd0, MODE_LOAD, 5'd15, 1'b1);
`ifdef CADDER_PIPE_OVF_EN
    check("ovf_after_load", {31'd0, ovf}, 32'd0);
`endif
    send(4'd15, 4'd0, MODE_ACC, 5'd30, 1'b1);
`ifdef CADDER_PIPE_OVF_EN
    check("ovf_after_acc1", {31'd0, ovf}, 32'd0);
`endif
    send(4'd15, 4'd0, MODE_ACC, 5'd13, 1'b1);
`ifdef CADDER_PIPE_OVF_EN
    check("ovf_after_acc2", {31'd0, ovf}, 32'd1);
`endif
    send(4'd0, 4'd0, MODE_LOAD, 5'd0, 1'b1);
`ifdef CADDER_PIPE_OVF_EN
    check("ovf_cleared", {31'd0, ovf}, 32'd0);
`endif
    drain();

    // Backpressure: hold out_ready low for 3 cycles once the first result shows.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        send(4'd1, 4'd1, MODE_ADD, 5'd2, 1'b0);
        send(4'd2, 4'd2, MODE_ADD, 5'd4, 1'b0);
        send(4'd3, 4'd3, MODE_ADD, 5'd6, 1'b0);
        send(4'd4, 4'd4, MODE_ADD, 5'd8, 1'b0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        #3;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          #3;
          n++;
        end
        for (int k = 0; k < 3; k++) begin
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_z_hold", {27'd0, Z}, 32'd2);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          if (k < 2) begin
            @(negedge clk);
            #3;
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with acc=7 and two transactions in flight.
    send(4'd7, 4'd0, MODE_LOAD, 5'd7, 1'b1);
    drain();
    send(4'd1, 4'd1, MODE_ADD, 5'd2, 1'b0);
    send(4'd2, 4'd2, MODE_ADD, 5'd4, 1'b0);
    check("inflight_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_z", {27'd0, Z}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("no_stale_out", {31'd0, out_valid}, 32'd0);
    end
    send(4'd1, 4'd0, MODE_ACC, 5'd1, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cadder_pipe.md
Name: cadder_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit clocked adder used in the pytest golden flow.
- Adds generic WIDTH, configurable LATENCY, add/sub/accumulate modes, and a valid/ready handshake with backpressure.
- Keeps CARRY_ERROR fault injection and makes the faulted bit position selectable, so golden-model mismatch tests exercise any carry position.

Parameters:
- WIDTH, 4, operand width; output is WIDTH+1 bits.
- LATENCY, 2, cycles from input accept to out_valid with no stall; legal range 1..4.
- CARRY_ERROR, 0, 0 = exact arithmetic; nonzero = carry out of bit ERR_BIT forced to 0 in every mode.
- ERR_BIT, 0, bit index whose carry-out is dropped; legal range 0..WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  A/B/mode valid.
- in_ready  out  1  block accepts a transfer this cycle.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned; ignored in modes 10/11.
- mode  in  2  00 add, 01 sub (A-B), 10 accumulate (acc+A), 11 load acc with A.
- out_valid  out  1  Z valid.
- out_ready  in  1  consumer accepts Z.
- Z  out  WIDTH+1  result.

Behaviour:
- Reset: out_valid=0, Z=0, acc=0, all stage valids=0. Takes effect immediately; in-flight transactions are discarded. in_ready=1 while rst is high and after release.
- Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
- Stall rule: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - On stall the whole pipeline freezes. Z and out_valid stay stable until delivered.
  - No bubble removal is required.
- Stage 1 computes the result from the core adder. Stages 2..LATENCY are register delays.
- Result becomes out_valid exactly LATENCY cycles after accept when unstalled. Results emerge in accept order, none lost or duplicated.
- Core adder, WIDTH+1 bits wide: X + Y + cin, modulo 2^(WIDTH+1).
  - With CARRY_ERROR≠0, the carry from bit ERR_BIT into bit ERR_BIT+1 is 0; all other carries are normal.
- Mode 00: X={0,A}, Y={0,B}, cin=0. Range 0..2^(WIDTH+1)-2; no wrap.
- Mode 01: X={0,A}, Y=~{0,B}, cin=1. Z is two's-complement A-B; Z[WIDTH]=1 means negative.
- Mode 10: X=acc, Y={0,A}, cin=0. acc<=result at accept. Wraps modulo 2^(WIDTH+1).
- Mode 11: result={0,A}, bypassing the adder; acc<=result.
- acc updates at accept, not at output. Back-to-back accumulates each see the previous value; no hazard.
- Simultaneous accept and deliver in one cycle is legal and sustains full throughput.

Optional Feature:
- Macro: CADDER_PIPE_OVF_EN.
- Defined:
  - Extra output port ovf, 1 bit, a sticky flag registered alongside acc.
  - Set at accept of mode 10 when the true sum ≥ 2^(WIDTH+1).
  - Cleared by mode 11 accept or rst; reset value 0.
  - Simultaneous set and clear cannot occur (different modes).
- Undefined: port absent, no logic generated.

Decomposition:
- Package cadder_pkg:
  - mode typedef/enum: MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC=2'b10, MODE_LOAD=2'b11.
  - MAX_LATENCY=4 constant.
- Sub-module cadder_core: purely combinational ripple adder, parameters WIDTH and CARRY_ERROR/ERR_BIT, ports X, Y, cin, S.
- cadder_pipe holds handshake, acc, and stage registers.

Test Plan (WIDTH=4, LATENCY=2 unless stated):
- Add, A=9, B=8, mode 00, out_ready=1 -> Z=5'd17 with out_valid exactly 2 cycles after accept.
- CARRY_ERROR=1, ERR_BIT=3, A=9, B=8 -> Z=5'd1. With ERR_BIT=0, A=1, B=1 -> Z=5'd0.
- Sub, A=3, B=5 -> Z=5'b11110. Sub, A=5, B=3 -> Z=5'd2.
- Mode 11 A=15, then mode 10 A=15 twice, back-to-back -> Z=15, 30, 13. ovf 0,0,1; a subsequent mode 11 A=0 clears ovf.
- Stream 4 adds (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 3 cycles after the first out_valid:
  - in_ready drops during the stall.
  - Z holds 2 while stalled.
  - Outputs 2, 4, 6, 8 in order, none dropped or repeated.
- rst pulsed mid-cycle with 2 transactions in flight and acc=7:
  - out_valid=0 and Z=0 immediately.
  - No stale outputs after release.
  - Mode 10 A=1 -> Z=1.
